// File: rtl/fpdivsqrt_pkg.sv
// Shared definitions for the FP div/sqrt response stage.
// Holds the one-hot format codes, the NaN-box fill constants, the metadata
// and writeback entry layouts, and the NaN-boxing helper.
package fpdivsqrt_pkg;

    localparam logic [2:0] FMT_F16 = 3'b001;
    localparam logic [2:0] FMT_F32 = 3'b010;
    localparam logic [2:0] FMT_F64 = 3'b100;

    // Tag storage width inside the entries; the stage's TAG_W must not exceed it.
    localparam int PKG_TAG_W = 5;

    localparam logic [47:0] F16_BOX = 48'hFFFF_FFFF_FFFF;
    localparam logic [31:0] F32_BOX = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [2:0]           fmt;
        logic [PKG_TAG_W-1:0] tag;
    } meta_t;

    typedef struct packed {
        logic [63:0]          data;
        logic [PKG_TAG_W-1:0] tag;
        logic [4:0]           fflags;
    } wb_entry_t;

    // Non-one-hot formats fall through unchanged; the stage flags them separately.
    function automatic logic [63:0] nan_box(input logic [2:0] fmt, input logic [63:0] res);
        logic [63:0] boxed;
        case (fmt)
            FMT_F16: boxed = {F16_BOX, res[15:0]};
            FMT_F32: boxed = {F32_BOX, res[31:0]};
            default: boxed = res;
        endcase
        return boxed;
    endfunction

endpackage

// File: rtl/fpdivsqrt_resp_stage_if.sv
// Handshake bundle between the div/sqrt unit, its issue logic and the
// register-file writeback port.
//   start_*   : issue metadata captured on each accepted start
//   finish_*  : divider result handshake and raw result/flags
//   wb_*      : NaN-boxed writeback entry toward the register file
// slave modport is the response stage; master is the surrounding logic.
interface fpdivsqrt_resp_stage_if #(
    parameter int TAG_W = 5
) ();
    logic             start_fire_i;
    logic [2:0]       start_fp_format_i;
    logic [TAG_W-1:0] start_tag_i;
    logic             meta_ready_o;
    logic             finish_valid_i;
    logic             finish_ready_o;
    logic [63:0]      fpdivsqrt_res_i;
    logic [4:0]       fflags_i;
    logic             wb_valid_o;
    logic             wb_ready_i;
    logic [63:0]      wb_data_o;
    logic [TAG_W-1:0] wb_tag_o;
    logic [4:0]       wb_fflags_o;

    modport slave (
        input  start_fire_i, start_fp_format_i, start_tag_i,
        input  finish_valid_i, fpdivsqrt_res_i, fflags_i, wb_ready_i,
        output meta_ready_o, finish_ready_o,
        output wb_valid_o, wb_data_o, wb_tag_o, wb_fflags_o
    );

    modport master (
        output start_fire_i, start_fp_format_i, start_tag_i,
        output finish_valid_i, fpdivsqrt_res_i, fflags_i, wb_ready_i,
        input  meta_ready_o, finish_ready_o,
        input  wb_valid_o, wb_data_o, wb_tag_o, wb_fflags_o
    );
endinterface

// File: rtl/fpdivsqrt_sync_fifo.sv
// Small synchronous FIFO with wrap-bit pointers.
// Ports: clk, rst_n (async active-low), flush (sync clear, overrides push/pop),
//        push/push_data, pop/pop_data (head entry), full, empty.
// Push while full and pop while empty are ignored.
module fpdivsqrt_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty    = (wr_ptr == rd_ptr);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end
endmodule

// File: rtl/fpdivsqrt_resp_stage.sv
// Writeback/response stage for the scalar FP div/sqrt unit.
// Captures {format, tag} on every accepted start, pops it when the divider
// finishes, NaN-boxes the result and queues {data, tag, fflags} for writeback.
// Ports: clk, rst_n (async active-low), flush_i (sync clear of both FIFOs),
//        bus (handshake bundle, slave side), fflags_acc_o / fflags_clr_i
//        (sticky flag accumulator).
// Build option FPDIVSQRT_RESP_FFLAGS_ACC_EN: when defined, fflags_acc_o
// accumulates the flags of every popped writeback; otherwise it is tied to 0
// and fflags_clr_i is ignored.
module fpdivsqrt_resp_stage
    import fpdivsqrt_pkg::*;
#(
    parameter int TAG_W      = PKG_TAG_W,
    parameter int META_DEPTH = 2,
    parameter int OUT_DEPTH  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush_i,
    fpdivsqrt_resp_stage_if.slave   bus,
    output logic [4:0]              fflags_acc_o,
    input  logic                    fflags_clr_i
);
    meta_t     meta_in, meta_head;
    wb_entry_t out_in, out_head;
    logic      meta_full, meta_empty;
    logic      out_full, out_empty;
    logic      fin_fire;
    logic      wb_pop;

    assign meta_in = {bus.start_fp_format_i, PKG_TAG_W'(bus.start_tag_i)};

    fpdivsqrt_sync_fifo #(.WIDTH($bits(meta_t)), .DEPTH(META_DEPTH)) u_meta_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush_i),
        .push      (bus.start_fire_i),
        .push_data (meta_in),
        .pop       (fin_fire),
        .pop_data  (meta_head),
        .full      (meta_full),
        .empty     (meta_empty)
    );

    // Ready is derived from state only, so finish_valid_i never reaches wb_valid_o
    // in the same cycle.
    assign bus.meta_ready_o   = !meta_full;
    assign bus.finish_ready_o = !meta_empty && !out_full;
    assign fin_fire           = bus.finish_valid_i && bus.finish_ready_o;

    assign out_in = {nan_box(meta_head.fmt, bus.fpdivsqrt_res_i), meta_head.tag, bus.fflags_i};

    fpdivsqrt_sync_fifo #(.WIDTH($bits(wb_entry_t)), .DEPTH(OUT_DEPTH)) u_out_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush_i),
        .push      (fin_fire),
        .push_data (out_in),
        .pop       (wb_pop),
        .pop_data  (out_head),
        .full      (out_full),
        .empty     (out_empty)
    );

    assign bus.wb_valid_o  = !out_empty;
    assign bus.wb_data_o   = out_head.data;
    assign bus.wb_tag_o    = TAG_W'(out_head.tag);
    assign bus.wb_fflags_o = out_head.fflags;
    assign wb_pop          = bus.wb_valid_o && bus.wb_ready_i;

`ifdef FPDIVSQRT_RESP_FFLAGS_ACC_EN
    logic [4:0] fflags_acc;

    // Clear wins over a same-cycle pop; that pop's flags are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            fflags_acc <= '0;
        else if (fflags_clr_i) fflags_acc <= '0;
        else if (wb_pop)       fflags_acc <= fflags_acc | bus.wb_fflags_o;
    end

    assign fflags_acc_o = fflags_acc;
`else
    logic unused_fflags_clr;
    assign unused_fflags_clr = fflags_clr_i;
    assign fflags_acc_o      = '0;
`endif

    a_start_not_full: assert property (@(posedge clk) disable iff (!rst_n)
        bus.start_fire_i |-> !meta_full);

    a_fmt_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        fin_fire |-> $onehot(meta_head.fmt));

endmodule

// File: tb/tb_fpdivsqrt_resp_stage.sv
module tb_fpdivsqrt_resp_stage;
    localparam int TAG_W = 5;
`ifdef FPDIVSQRT_RESP_FFLAGS_ACC_EN
    localparam bit ACC_EN = 1'b1;
`else
    localparam bit ACC_EN = 1'b0;
`endif

    typedef struct {
        logic [2:0] fmt;
        logic [4:0] tag;
    } m_t;

    typedef struct {
        logic [63:0] d;
        logic [4:0]  tag;
        logic [4:0]  fl;
    } o_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       clr;
    logic [4:0] acc;

    fpdivsqrt_resp_stage_if #(.TAG_W(TAG_W)) bus ();

    fpdivsqrt_resp_stage #(.TAG_W(TAG_W), .META_DEPTH(2), .OUT_DEPTH(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (flush),
        .bus          (bus),
        .fflags_acc_o (acc),
        .fflags_clr_i (clr)
    );

    always #5 clk = ~clk;

    int   n_assert = 0;
    int   n_fail   = 0;
    m_t   mq[$];
    o_t   oq[$];
    logic [4:0] acc_m = '0;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    function automatic logic [63:0] box(input logic [2:0] fmt, input logic [63:0] r);
        case (fmt)
            3'b001:  return {48'hFFFF_FFFF_FFFF, r[15:0]};
            3'b010:  return {32'hFFFF_FFFF, r[31:0]};
            default: return r;
        endcase
    endfunction

    // One clock: drive at the falling edge, compare against the model, then
    // advance the model by what the rising edge will do.
    task automatic step(input bit st, input logic [2:0] fmt, input logic [4:0] tg,
                        input bit fv, input logic [63:0] res, input logic [4:0] fl,
                        input bit wbr, input bit fls, input bit cl);
        bit exp_mr, exp_fr, exp_wv, acc_st, fin, pop;
        m_t m;
        o_t o;
        bus.start_fire_i      = st;
        bus.start_fp_format_i = fmt;
        bus.start_tag_i       = tg;
        bus.finish_valid_i    = fv;
        bus.fpdivsqrt_res_i   = res;
        bus.fflags_i          = fl;
        bus.wb_ready_i        = wbr;
        flush                 = fls;
        clr                   = cl;
        #1;
        exp_mr = mq.size() < 2;
        exp_fr = (mq.size() != 0) && (oq.size() < 2);
        exp_wv = oq.size() != 0;
        chk("meta_ready", 64'(bus.meta_ready_o), 64'(exp_mr));
        chk("finish_ready", 64'(bus.finish_ready_o), 64'(exp_fr));
        chk("wb_valid", 64'(bus.wb_valid_o), 64'(exp_wv));
        chk("fflags_acc", 64'(acc), ACC_EN ? 64'(acc_m) : 64'd0);
        if (exp_wv) begin
            chk("wb_data", bus.wb_data_o, oq[0].d);
            chk("wb_tag", 64'(bus.wb_tag_o), 64'(oq[0].tag));
            chk("wb_fflags", 64'(bus.wb_fflags_o), 64'(oq[0].fl));
        end
        acc_st = st && exp_mr;
        fin    = fv && exp_fr;
        pop    = exp_wv && wbr;
        if (cl)       acc_m = '0;
        else if (pop) acc_m = acc_m | oq[0].fl;
        if (fls) begin
            mq.delete();
            oq.delete();
        end else begin
            if (pop) void'(oq.pop_front());
            if (fin) begin
                m = mq.pop_front();
                o.d = box(m.fmt, res);
                o.tag = m.tag;
                o.fl = fl;
                oq.push_back(o);
            end
            if (acc_st) begin
                m.fmt = fmt;
                m.tag = tg;
                mq.push_back(m);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input bit wbr);
        step(0, 3'b000, 5'd0, 0, 64'd0, 5'd0, wbr, 0, 0);
    endtask

    initial begin
        logic [2:0] fmts [3];
        logic [2:0] rf;
        bit         rs;
        logic [4:0] acc_before;
        fmts[0] = 3'b001; fmts[1] = 3'b010; fmts[2] = 3'b100;

        rst_n = 1'b0;
        flush = 0; clr = 0;
        bus.start_fire_i = 0; bus.start_fp_format_i = 0; bus.start_tag_i = 0;
        bus.finish_valid_i = 0; bus.fpdivsqrt_res_i = 0; bus.fflags_i = 0; bus.wb_ready_i = 0;
        repeat (2) @(negedge clk);
        chk("rst_meta_ready", 64'(bus.meta_ready_o), 64'd1);
        chk("rst_finish_ready", 64'(bus.finish_ready_o), 64'd0);
        chk("rst_wb_valid", 64'(bus.wb_valid_o), 64'd0);
        chk("rst_wb_data", bus.wb_data_o, 64'd0);
        chk("rst_wb_tag", 64'(bus.wb_tag_o), 64'd0);
        chk("rst_wb_fflags", 64'(bus.wb_fflags_o), 64'd0);
        chk("rst_acc", 64'(acc), 64'd0);
        rst_n = 1'b1;

        // Asynchronous reset with one op in flight.
        step(1, 3'b010, 5'd9, 0, 64'd0, 5'd0, 0, 0, 0);
        chk("pre_rst_finish_ready", 64'(bus.finish_ready_o), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_meta_ready", 64'(bus.meta_ready_o), 64'd1);
        chk("arst_wb_valid", 64'(bus.wb_valid_o), 64'd0);
        chk("arst_finish_ready", 64'(bus.finish_ready_o), 64'd0);
        mq.delete(); oq.delete(); acc_m = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // f32, tag 3.
        step(1, 3'b010, 5'd3, 0, 64'd0, 5'd0, 0, 0, 0);
        step(0, 3'b000, 5'd0, 1, 64'h0000_0000_3F80_0000, 5'd0, 0, 0, 0);
        chk("f32_data", bus.wb_data_o, 64'hFFFF_FFFF_3F80_0000);
        chk("f32_tag", 64'(bus.wb_tag_o), 64'd3);
        idle(1);

        // f16, tag 7.
        step(1, 3'b001, 5'd7, 0, 64'd0, 5'd0, 0, 0, 0);
        step(0, 3'b000, 5'd0, 1, 64'hDEAD_BEEF_0000_3C00, 5'b00001, 0, 0, 0);
        chk("f16_data", bus.wb_data_o, 64'hFFFF_FFFF_FFFF_3C00);
        chk("f16_fflags", 64'(bus.wb_fflags_o), 64'd1);
        chk("f16_tag", 64'(bus.wb_tag_o), 64'd7);
        idle(1);

        // Meta full, then output backpressure.
        step(1, 3'b100, 5'd10, 0, 64'd0, 5'd0, 0, 0, 0);
        step(1, 3'b100, 5'd11, 0, 64'd0, 5'd0, 0, 0, 0);
        chk("meta_full_ready", 64'(bus.meta_ready_o), 64'd0);
        step(0, 3'b000, 5'd0, 1, 64'h4000_0000_0000_0001, 5'd0, 0, 0, 0);
        chk("meta_free_ready", 64'(bus.meta_ready_o), 64'd1);
        step(1, 3'b100, 5'd12, 1, 64'h4010_0000_0000_0002, 5'd0, 0, 0, 0);
        chk("bp_finish_ready", 64'(bus.finish_ready_o), 64'd0);
        chk("bp_head_tag", 64'(bus.wb_tag_o), 64'd10);
        chk("bp_head_data", bus.wb_data_o, 64'h4000_0000_0000_0001);
        step(0, 3'b000, 5'd0, 1, 64'h4020_0000_0000_0003, 5'd0, 0, 0, 0);
        chk("bp_stall_ready", 64'(bus.finish_ready_o), 64'd0);
        step(0, 3'b000, 5'd0, 1, 64'h4020_0000_0000_0003, 5'd0, 1, 0, 0);
        chk("drain_tag1", 64'(bus.wb_tag_o), 64'd11);
        step(0, 3'b000, 5'd0, 1, 64'h4020_0000_0000_0003, 5'd0, 1, 0, 0);
        chk("drain_tag2", 64'(bus.wb_tag_o), 64'd12);
        idle(1);
        chk("drain_empty", 64'(bus.wb_valid_o), 64'd0);

        // Sticky flags, flush, clear.
        step(1, 3'b100, 5'd1, 0, 64'd0, 5'd0, 1, 0, 0);
        step(1, 3'b100, 5'd2, 0, 64'd0, 5'd0, 1, 0, 0);
        step(0, 3'b000, 5'd0, 1, 64'h1, 5'b10000, 1, 0, 0);
        step(0, 3'b000, 5'd0, 1, 64'h2, 5'b01000, 1, 0, 0);
        idle(1);
        chk("acc_nv_dz", 64'(acc), ACC_EN ? 64'h18 : 64'd0);
        acc_before = acc;
        step(1, 3'b010, 5'd4, 0, 64'd0, 5'd0, 0, 0, 0);
        step(0, 3'b000, 5'd0, 1, 64'h3, 5'b00100, 0, 0, 0);
        step(0, 3'b000, 5'd0, 0, 64'd0, 5'd0, 0, 1, 0);
        chk("flush_wb_valid", 64'(bus.wb_valid_o), 64'd0);
        chk("flush_acc_kept", 64'(acc), 64'(acc_before));
        step(0, 3'b000, 5'd0, 0, 64'd0, 5'd0, 0, 0, 1);
        chk("clr_acc", 64'(acc), 64'd0);

        // Randomized traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            rs = ($urandom_range(0, 1) == 1) && (mq.size() < 2);
            rf = fmts[$urandom_range(0, 2)];
            step(rs, rf, 5'($urandom), $urandom_range(0, 1) == 1,
                 {$urandom, $urandom}, 5'($urandom), $urandom_range(0, 2) != 0,
                 $urandom_range(0, 31) == 0, $urandom_range(0, 39) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/fpdivsqrt_resp_stage.md
Name: fpdivsqrt_resp_stage

Overview:
- Downstream writeback/response stage for the scalar FP div/sqrt unit.
- Records issue metadata (format, destination tag) at each accepted start, then consumes the unit's finish handshake.
- NaN-boxes f16/f32 results to 64 bits, pairs each result with its tag, and buffers it in a 2-entry output FIFO toward the register-file writeback port.
- Optionally accumulates sticky fflags for the CSR block.

Parameters:
- TAG_W, 5, width of the destination-register tag carried with each op.
- META_DEPTH, 2, in-flight metadata FIFO entries (power of 2, >=2).
- OUT_DEPTH, 2, output FIFO entries (power of 2, >=2).

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- flush_i  in  1  synchronous flush of all buffered state
- start_fire_i  in  1  divider start handshake occurred this cycle (start_valid & start_ready)
- start_fp_format_i  in  3  one-hot format of started op: [0] f16, [1] f32, [2] f64
- start_tag_i  in  TAG_W  destination tag of started op
- meta_ready_o  out  1  metadata FIFO not full; upstream gates the divider's start_valid with it
- finish_valid_i  in  1  divider result valid
- finish_ready_o  out  1  to divider finish_ready
- fpdivsqrt_res_i  in  64  raw divider result
- fflags_i  in  5  divider exception flags {NV,DZ,OF,UF,NX}
- wb_valid_o  out  1  writeback entry available
- wb_ready_i  in  1  writeback accepted
- wb_data_o  out  64  NaN-boxed result
- wb_tag_o  out  TAG_W  destination tag
- wb_fflags_o  out  5  per-op flags
- fflags_acc_o  out  5  sticky OR of flags of all popped writebacks (macro-dependent)
- fflags_clr_i  in  1  clear sticky flags (macro-dependent)

Behaviour:
- Reset (rst_n=0, async): both FIFOs empty, pointers 0, meta_ready_o=1, finish_ready_o=0, wb_valid_o=0, wb_data_o/wb_tag_o/wb_fflags_o=0, fflags_acc_o=0.
- Meta push: start_fire_i=1 writes {format, tag}.
  - meta_ready_o = !meta_full. It does not account for a same-cycle pop.
  - start_fire_i while full is illegal; the push is dropped and a simulation assertion fires.
- Finish pop:
  - finish_ready_o = meta_nonempty & !out_full.
  - fin_fire = finish_valid_i & finish_ready_o pops the meta head and pushes {boxed result, tag, fflags_i} into the output FIFO.
- NaN-boxing by meta-head format:
  - f16 -> {48'hFFFF_FFFF_FFFF, res[15:0]}
  - f32 -> {32'hFFFF_FFFF, res[31:0]}
  - f64 -> res unchanged
  - non-one-hot format -> res unchanged, plus assertion.
- Output FIFO: wb_valid_o = !out_empty; outputs driven from the head entry; pop on wb_valid_o & wb_ready_i.
  - Simultaneous push and pop on a full FIFO is not allowed (finish_ready_o is already 0).
  - Simultaneous push and pop on a non-full FIFO keeps the count unchanged.
- Latency: fin_fire at cycle N -> wb_valid_o=1 at cycle N+1 if the FIFO was empty. No combinational path from finish_valid_i to wb_valid_o.
- Pointers: log2(depth)+1 bits with wrap bit. full = MSBs differ & LSBs equal; empty = pointers equal.
- flush_i (sync): clears both FIFOs next cycle, overriding any same-cycle push/pop. fflags_acc_o is unaffected.
- Order: results return in issue order (single in-order unit), so the meta head always matches the finishing op.

Optional Feature:
- Macro FPDIVSQRT_RESP_FFLAGS_ACC_EN.
- Defined: fflags_acc_o <= fflags_acc_o | wb_fflags_o on each wb pop. fflags_clr_i=1 zeroes it next cycle. Clear takes priority over a same-cycle pop, whose flags are lost.
- Undefined: no accumulator register; fflags_acc_o tied to 0; fflags_clr_i ignored.

Decomposition:
- Shared package fpdivsqrt_pkg holds:
  - format one-hot constants FMT_F16/FMT_F32/FMT_F64
  - typedef meta_t {fmt[2:0], tag}
  - typedef wb_entry_t {data[63:0], tag, fflags[4:0]}
  - NaN-box constants F16_BOX/F32_BOX
- One natural sub-module: fpdivsqrt_sync_fifo (parameterised width/depth, push/pop/flush, full/empty), instantiated twice.

Test Plan:
- Reset then idle: rst_n low mid-operation with 1 meta entry -> meta_ready_o=1, wb_valid_o=0, finish_ready_o=0 immediately (async).
- f32 tag 3: start_fire_i with fmt=3'b010, then finish res=64'h0000_0000_3F80_0000, fflags=0 -> next cycle wb_data_o=64'hFFFF_FFFF_3F80_0000, wb_tag_o=3.
- f16 tag 7: fmt=3'b001, res=64'hDEAD_BEEF_0000_3C00, fflags=5'b00001 -> wb_data_o=64'hFFFF_FFFF_FFFF_3C00, wb_fflags_o=5'b00001.
- Backpressure:
  - wb_ready_i=0, two f64 ops finish -> out full, finish_ready_o=0, third finish_valid_i stalls.
  - Release wb_ready_i -> entries drain in order with the correct tags.
- Meta full: two start_fire_i with no finish -> meta_ready_o=0; one finish -> meta_ready_o=1 next cycle.
- Flush and flags: two ops with NV and DZ popped -> fflags_acc_o=5'b11000 (macro on) / 0 (off). Then flush_i with 1 pending entry -> wb_valid_o=0 and fflags_acc_o unchanged. Then fflags_clr_i -> 0.
